// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
// Segments are active-high, anodes are active-low.
package display_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Replicate this bit across the anode bus to turn every digit off.
    localparam logic ANODE_OFF = 1'b1;

endpackage

// File: rtl/sevenseg.sv
// Hex nibble to seven-segment decoder, bit order {g,f,e,d,c,b,a}, active-high.
// Values 10..15 render as A, b, C, d, E, F.
module sevenseg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b0000000;
        case (i_nibble)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for NDIGITS common-anode seven-segment digits,
// with guard blanking, frame-synchronous shadow updates and leading-zero blanking.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [4*NDIGITS-1:0]       digits,
    input  logic                       load,
    input  logic                       lz_suppress,
    output logic [NDIGITS-1:0]         anode,
    output logic [6:0]                 seg,
    output logic [$clog2(NDIGITS)-1:0] digit_idx,
    output logic                       frame_done
);

    localparam int IDX_W = $clog2(NDIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIGITS - 1);

    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    scan_state_t          r_state;
    logic [4*NDIGITS-1:0] r_staging;
    logic [4*NDIGITS-1:0] r_shadow;
    logic                 r_pending;
    logic [NDIGITS-1:0]   r_anode;
    logic [6:0]           r_seg;
    logic                 r_frame_done;

    logic [CNT_W-1:0]     w_cnt_next;
    logic [IDX_W-1:0]     w_idx_next;
    scan_state_t          w_state_next;
    logic [4*NDIGITS-1:0] w_staging_next;
    logic [4*NDIGITS-1:0] w_shadow_next;
    logic                 w_pending_next;
    logic [NDIGITS-1:0]   w_anode_next;
    logic [6:0]           w_seg_next;

    logic                 w_slot_end;
    logic                 w_wrap;
    logic [3:0]           w_nib [NDIGITS];
    logic [NDIGITS-1:0]   w_sel_n;
    logic [NDIGITS-1:0]   w_suppress;
    logic [3:0]           w_dec_in;
    logic [6:0]           w_dec_seg;
    logic                 w_lit;

    // Slot counter, slot index and FSM next state.
    always_comb begin
        w_slot_end   = enable && (r_cnt == CNT_LAST);
        w_wrap       = w_slot_end && (r_idx == IDX_LAST);
        w_cnt_next   = '0;
        w_idx_next   = '0;
        w_state_next = GUARD;
        if (enable) begin
            w_cnt_next = w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) begin
                w_idx_next = w_wrap ? '0 : r_idx + 1'b1;
            end else begin
                w_idx_next = r_idx;
            end
            case (r_state)
                GUARD:   w_state_next = (w_cnt_next == CNT_BLANK) ? DRIVE : GUARD;
                DRIVE:   w_state_next = w_slot_end ? GUARD : DRIVE;
                default: w_state_next = GUARD;
            endcase
        end
    end

    // A load on the wrap edge lands in staging first, so the shadow sees it directly.
    always_comb begin
        w_staging_next = load ? digits : r_staging;
        w_pending_next = load | r_pending;
        w_shadow_next  = r_shadow;
        if (w_wrap && w_pending_next) begin
            w_shadow_next  = w_staging_next;
            w_pending_next = 1'b0;
        end
    end

    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
        assign w_nib[gi]   = w_shadow_next[4*gi +: 4];
        assign w_sel_n[gi] = (w_idx_next != IDX_W'(gi));
    end

    // Digit k is a leading zero when it and every digit to its left are zero.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        w_suppress = '0;
        for (int k = NDIGITS - 1; k >= 1; k--) begin
            zero_run      = zero_run && (w_nib[k] == 4'h0);
            w_suppress[k] = lz_suppress && zero_run;
        end
    end

    assign w_dec_in = w_nib[w_idx_next];

    sevenseg u_sevenseg (
        .i_nibble (w_dec_in),
        .o_seg    (w_dec_seg)
    );

    always_comb begin
        w_lit        = (w_state_next == DRIVE) && !w_suppress[w_idx_next];
        w_anode_next = w_lit ? w_sel_n : {NDIGITS{ANODE_OFF}};
        w_seg_next   = w_lit ? w_dec_seg : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_state      <= GUARD;
            r_staging    <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_anode      <= {NDIGITS{ANODE_OFF}};
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_state      <= w_state_next;
            r_staging    <= w_staging_next;
            r_shadow     <= w_shadow_next;
            r_pending    <= w_pending_next;
            r_anode      <= w_anode_next;
            r_seg        <= w_seg_next;
            r_frame_done <= w_wrap;
        end
    end

    assign anode      = r_anode;
    assign seg        = r_seg;
    assign digit_idx  = r_idx;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised and directed bench for display_scan_ctrl against a cycle-count
// based reference model (position in frame derived from elapsed enabled cycles).
module tb_display_scan_ctrl;

    localparam int NDIGITS      = 4;
    localparam int REFRESH_DIV  = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = NDIGITS * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] digits;
    logic        load;
    logic        lz_suppress;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    // Reference model state: enabled cycles since last restart, staging/shadow/pending.
    int          m_t;
    logic [15:0] m_stg;
    logic [15:0] m_shd;
    logic        m_pend;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_seg;
    logic [1:0]  exp_idx;
    logic        exp_fd;

    display_scan_ctrl #(
        .NDIGITS      (NDIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .digits      (digits),
        .load        (load),
        .lz_suppress (lz_suppress),
        .anode       (anode),
        .seg         (seg),
        .digit_idx   (digit_idx),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    function automatic int phase();
        return m_t % FRAME;
    endfunction

    // Advance one clock, update the model with the inputs seen at that edge,
    // and return at the following negedge with expected outputs ready.
    task automatic tick();
        logic wrap;
        int   c;
        int   k;
        logic lit;
        @(posedge clk);
        if (!reset) begin
            m_t    = 0;
            m_stg  = '0;
            m_shd  = '0;
            m_pend = 1'b0;
            exp_fd = 1'b0;
        end else begin
            wrap = enable && (((m_t + 1) % FRAME) == 0);
            if (load) begin
                m_stg  = digits;
                m_pend = 1'b1;
            end
            if (wrap && m_pend) begin
                m_shd  = m_stg;
                m_pend = 1'b0;
            end
            exp_fd = wrap;
            m_t    = enable ? m_t + 1 : 0;
        end
        c   = m_t % REFRESH_DIV;
        k   = (m_t / REFRESH_DIV) % NDIGITS;
        lit = (c >= BLANK_CYCLES) && !(lz_suppress && (k > 0) && ((m_shd >> (4 * k)) == 16'h0));
        exp_anode = lit ? ~(4'b0001 << k) : 4'hF;
        exp_seg   = lit ? ref_seg(m_shd[4*k +: 4]) : 7'h00;
        exp_idx   = k[1:0];
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; load = 1'b0; lz_suppress = 1'b0; digits = 16'h0;
        tick();
        tick();
        tests++;
        if (anode !== 4'hF) begin fails++; $display("FAIL reset_anode got=%b want=1111", anode); end
        tests++;
        if (seg !== 7'h00) begin fails++; $display("FAIL reset_seg got=%h want=00", seg); end
        tests++;
        if (digit_idx !== 2'd0) begin fails++; $display("FAIL reset_idx got=%0d want=0", digit_idx); end
        tests++;
        if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got=%b want=0", frame_done); end
        tests++;
        if (dut.r_pending !== 1'b0) begin fails++; $display("FAIL reset_pending got=%b want=0", dut.r_pending); end
        $display("[TB] reset: anode=%b seg=%h idx=%0d fd=%b", anode, seg, digit_idx, frame_done);
        reset = 1'b1;
    endtask

    task automatic test_scan_timing();
        int pulses = 0;
        logic [3:0] seq [12];
        enable = 1'b1;
        seq[0] = anode;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (i < 11) seq[i+1] = anode;
            if (frame_done) pulses++;
            tests++;
            if ({anode, seg, digit_idx, frame_done} !== {exp_anode, exp_seg, exp_idx, exp_fd}) begin
                fails++;
                $display("FAIL scan t=%0d anode=%b/%b seg=%h/%h idx=%0d/%0d fd=%b/%b", m_t,
                         anode, exp_anode, seg, exp_seg, digit_idx, exp_idx, frame_done, exp_fd);
            end
        end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (seq[i] !== ((i < 2) ? 4'hF : (i < 8) ? 4'hE : (i < 10) ? 4'hF : 4'hD)) begin
                fails++;
                $display("FAIL scan_seq cycle=%0d got=%b", i, seq[i]);
            end
        end
        tests++;
        if (pulses !== 2) begin fails++; $display("FAIL frame_pulses got=%0d want=2", pulses); end
        $display("[TB] scan timing: %0d cycles, %0d frame pulses", 2 * FRAME, pulses);
    endtask

    task automatic test_load_midframe();
        logic wrapped = 1'b0;
        while (phase() != 12) tick();
        digits = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (frame_done) wrapped = 1'b1;
            tests++;
            if ({anode, seg, digit_idx, frame_done} !== {exp_anode, exp_seg, exp_idx, exp_fd}) begin
                fails++;
                $display("FAIL load_mid t=%0d anode=%b/%b seg=%h/%h idx=%0d/%0d fd=%b/%b", m_t,
                         anode, exp_anode, seg, exp_seg, digit_idx, exp_idx, frame_done, exp_fd);
            end
            if (!wrapped && phase() == 26) begin
                tests++;
                if (seg !== 7'h3F) begin fails++; $display("FAIL no_tear got=%h want=3f", seg); end
            end
            if (wrapped && phase() == 2 && i < FRAME) begin
                tests++;
                if (seg !== 7'h66) begin fails++; $display("FAIL slot0_new got=%h want=66", seg); end
            end
            if (wrapped && phase() == 26 && i < FRAME + 20) begin
                tests++;
                if (seg !== 7'h06) begin fails++; $display("FAIL slot3_new got=%h want=06", seg); end
            end
        end
        $display("[TB] load mid-frame 1234: shadow=%h", m_shd);
    endtask

    task automatic test_lz_suppress();
        logic [15:0] vals [2];
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
        lz_suppress = 1'b1;
        for (int v = 0; v < 2; v++) begin
            digits = vals[v]; load = 1'b1;
            tick();
            load = 1'b0;
            for (int i = 0; i < 2 * FRAME; i++) begin
                tick();
                tests++;
                if ({anode, seg, digit_idx, frame_done} !== {exp_anode, exp_seg, exp_idx, exp_fd}) begin
                    fails++;
                    $display("FAIL lz t=%0d anode=%b/%b seg=%h/%h idx=%0d/%0d fd=%b/%b", m_t,
                             anode, exp_anode, seg, exp_seg, digit_idx, exp_idx, frame_done, exp_fd);
                end
                if (i >= FRAME && (phase() % REFRESH_DIV) == 4) begin
                    tests++;
                    case (phase() / REFRESH_DIV)
                        0: if ({anode, seg} !== {4'hE, 7'h3F}) begin fails++; $display("FAIL lz_slot0 got=%b/%h", anode, seg); end
                        1: if ({anode, seg} !== ((v == 0) ? {4'hD, 7'h6D} : {4'hF, 7'h00})) begin fails++; $display("FAIL lz_slot1 got=%b/%h", anode, seg); end
                        default: if ({anode, seg} !== {4'hF, 7'h00}) begin fails++; $display("FAIL lz_dark got=%b/%h", anode, seg); end
                    endcase
                end
            end
            $display("[TB] lz_suppress digits=%h", vals[v]);
        end
        lz_suppress = 1'b0;
    endtask

    task automatic test_load_on_wrap();
        for (int i = 0; i < FRAME && ((m_t + 1) % FRAME) != 0; i++) tick();
        digits = 16'h9876; load = 1'b1;
        tick();
        load = 1'b0;
        tests++;
        if (frame_done !== 1'b1) begin fails++; $display("FAIL wrap_fd got=%b want=1", frame_done); end
        tests++;
        if (dut.r_pending !== 1'b0) begin fails++; $display("FAIL wrap_pending got=%b want=0", dut.r_pending); end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            tests++;
            if ({anode, seg, digit_idx, frame_done} !== {exp_anode, exp_seg, exp_idx, exp_fd}) begin
                fails++;
                $display("FAIL load_wrap t=%0d anode=%b/%b seg=%h/%h idx=%0d/%0d fd=%b/%b", m_t,
                         anode, exp_anode, seg, exp_seg, digit_idx, exp_idx, frame_done, exp_fd);
            end
            if (i == 1) begin
                tests++;
                if (seg !== 7'h7D) begin fails++; $display("FAIL wrap_slot0 got=%h want=7d", seg); end
            end
        end
        $display("[TB] load on wrap 9876: pending=%b", dut.r_pending);
    endtask

    task automatic test_enable_drop();
        while (phase() != 2 * REFRESH_DIV + 4) tick();
        enable = 1'b0;
        tick();
        tests++;
        if ({anode, seg, digit_idx} !== {4'hF, 7'h00, 2'd0}) begin
            fails++; $display("FAIL disable got=%b/%h/%0d want=1111/00/0", anode, seg, digit_idx);
        end
        digits = 16'h4321; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tests++;
        if (dut.r_pending !== 1'b1) begin fails++; $display("FAIL disabled_load got=%b want=1", dut.r_pending); end
        enable = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            tests++;
            if ({anode, seg, digit_idx, frame_done} !== {exp_anode, exp_seg, exp_idx, exp_fd}) begin
                fails++;
                $display("FAIL reenable t=%0d anode=%b/%b seg=%h/%h idx=%0d/%0d fd=%b/%b", m_t,
                         anode, exp_anode, seg, exp_seg, digit_idx, exp_idx, frame_done, exp_fd);
            end
            if (i < 3) begin
                tests++;
                if (anode !== ((i < 1) ? 4'hF : 4'hE)) begin fails++; $display("FAIL reenable_anode cycle=%0d got=%b", i, anode); end
            end
        end
        $display("[TB] enable drop/restore done");
    endtask

    task automatic test_reset_midslot();
        while (phase() != 3 * REFRESH_DIV + 3) tick();
        digits = 16'hABCD; load = 1'b1;
        tick();
        load = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests++;
        if ({anode, seg, digit_idx, frame_done} !== {4'hF, 7'h00, 2'd0, 1'b0}) begin
            fails++; $display("FAIL midreset got=%b/%h/%0d/%b", anode, seg, digit_idx, frame_done);
        end
        tests++;
        if (dut.r_pending !== 1'b0) begin fails++; $display("FAIL midreset_pending got=%b want=0", dut.r_pending); end
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            tests++;
            if ({anode, seg, digit_idx, frame_done} !== {exp_anode, exp_seg, exp_idx, exp_fd}) begin
                fails++;
                $display("FAIL post_reset t=%0d anode=%b/%b seg=%h/%h idx=%0d/%0d fd=%b/%b", m_t,
                         anode, exp_anode, seg, exp_seg, digit_idx, exp_idx, frame_done, exp_fd);
            end
            if (i == FRAME + 1) begin
                tests++;
                if (seg !== 7'h3F) begin fails++; $display("FAIL discarded_load got=%h want=3f", seg); end
            end
        end
        $display("[TB] reset mid-slot 3 with pending load");
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            reset       = ($urandom_range(0, 299) != 0);
            enable      = ($urandom_range(0, 24) != 0);
            load        = ($urandom_range(0, 19) == 0);
            digits      = 16'($urandom);
            lz_suppress = 1'($urandom_range(0, 1));
            tick();
            tests++;
            if ({anode, seg, digit_idx, frame_done, dut.r_pending} !==
                {exp_anode, exp_seg, exp_idx, exp_fd, m_pend}) begin
                fails++;
                $display("FAIL random i=%0d anode=%b/%b seg=%h/%h idx=%0d/%0d fd=%b/%b pend=%b/%b", i,
                         anode, exp_anode, seg, exp_seg, digit_idx, exp_idx, frame_done, exp_fd,
                         dut.r_pending, m_pend);
            end
        end
        reset = 1'b1; enable = 1'b1; load = 1'b0;
        $display("[TB] random: 2500 cycles");
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_load_midframe();
        test_lz_suppress();
        test_load_on_wrap();
        test_enable_drop();
        test_reset_midslot();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
